// File: rtl/crc8_frame_seq.sv
// Frame sequencer for an external CRC-8 engine: clears it per frame, feeds payload bytes,
// then either appends the CRC to the output stream (mode 0) or checks a received CRC (mode 1).
module crc8_frame_seq #(
    parameter int MAX_LEN = 64,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mode,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [7:0]       s_data,
    input  logic             s_last,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [7:0]       m_data,
    output logic             m_last,
    output logic             eng_clr,
    output logic             eng_valid,
    output logic [7:0]       eng_data,
    output logic             eng_mode,
    output logic [7:0]       eng_rx_crc,
    input  logic [7:0]       eng_crc,
    input  logic             eng_ok,
    output logic             busy,
    output logic             done,
    output logic             crc_ok,
    output logic             len_err,
    output logic [LEN_W-1:0] frame_len
);

    typedef enum logic [2:0] {IDLE, CLR, PAYLOAD, APPEND, ABORT, CHECK, DRAIN} state_t;

    state_t           state_reg;
    logic             mode_reg;
    logic [LEN_W-1:0] count_reg;
    logic [7:0]       rx_crc_reg;
    logic             done_reg;
    logic             crc_ok_reg;
    logic             len_err_reg;
    logic [LEN_W-1:0] frame_len_reg;

    logic at_max;
    logic s_fire;

    assign at_max = (count_reg == LEN_W'(MAX_LEN));
    assign s_fire = s_valid && s_ready;

    assign eng_clr    = (state_reg == CLR);
    assign eng_data   = s_data;
    assign eng_mode   = mode_reg;
    assign eng_rx_crc = rx_crc_reg;
    assign busy       = (state_reg != IDLE);
    assign done       = done_reg;
    assign crc_ok     = crc_ok_reg;
    assign len_err    = len_err_reg;
    assign frame_len  = frame_len_reg;

    // Streaming handshakes pass straight through in PAYLOAD, so they are decoded combinationally.
    always_comb begin
        s_ready   = 1'b0;
        m_valid   = 1'b0;
        m_data    = s_data;
        m_last    = 1'b0;
        eng_valid = 1'b0;
        case (state_reg)
            PAYLOAD: begin
                if (!mode_reg) begin
                    s_ready   = m_ready && !at_max;
                    m_valid   = s_valid && !at_max;
                    eng_valid = s_valid && m_ready && !at_max;
                end else begin
                    s_ready   = 1'b1;
                    eng_valid = s_valid && !s_last && !at_max;
                end
            end
            APPEND: begin
                m_valid = 1'b1;
                m_data  = eng_crc;
                m_last  = 1'b1;
            end
            ABORT: begin
                // Inverted CRC guarantees the receiver rejects the truncated frame.
                m_valid = 1'b1;
                m_data  = ~eng_crc;
                m_last  = 1'b1;
            end
            DRAIN: s_ready = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            mode_reg      <= 1'b0;
            count_reg     <= '0;
            rx_crc_reg    <= 8'h00;
            done_reg      <= 1'b0;
            crc_ok_reg    <= 1'b0;
            len_err_reg   <= 1'b0;
            frame_len_reg <= '0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (s_valid) begin
                        mode_reg  <= mode;
                        state_reg <= CLR;
                    end
                end
                CLR: begin
                    count_reg <= '0;
                    state_reg <= PAYLOAD;
                end
                PAYLOAD: begin
                    if (!mode_reg) begin
                        if (at_max) begin
                            state_reg <= ABORT;
                        end else if (s_fire) begin
                            count_reg <= count_reg + LEN_W'(1);
                            if (s_last) state_reg <= APPEND;
                        end
                    end else if (s_valid) begin
                        if (s_last) begin
                            rx_crc_reg <= s_data;
                            state_reg  <= CHECK;
                        end else if (at_max) begin
                            state_reg <= DRAIN;
                        end else begin
                            count_reg <= count_reg + LEN_W'(1);
                        end
                    end
                end
                APPEND: begin
                    if (m_ready) begin
                        done_reg      <= 1'b1;
                        crc_ok_reg    <= 1'b0;
                        len_err_reg   <= 1'b0;
                        frame_len_reg <= count_reg;
                        state_reg     <= IDLE;
                    end
                end
                ABORT: begin
                    if (m_ready) state_reg <= DRAIN;
                end
                CHECK: begin
                    done_reg      <= 1'b1;
                    crc_ok_reg    <= eng_ok;
                    len_err_reg   <= 1'b0;
                    frame_len_reg <= count_reg;
                    state_reg     <= IDLE;
                end
                DRAIN: begin
                    if (s_valid && s_last) begin
                        done_reg      <= 1'b1;
                        crc_ok_reg    <= 1'b0;
                        len_err_reg   <= 1'b1;
                        frame_len_reg <= count_reg;
                        state_reg     <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_crc8_frame_seq.sv
// Bench for crc8_frame_seq: hosts a behavioural CRC-8 engine and checks frames against
// a frame-level reference model (whole-frame CRC, truncation rules, expected beats).
module tb_crc8_frame_seq;
    localparam int MAX_LEN = 4;
    localparam int LEN_W   = $clog2(MAX_LEN + 1);

    logic             clk = 1'b0;
    logic             rst, mode, s_valid, s_ready, s_last;
    logic [7:0]       s_data, m_data, eng_data, eng_rx_crc, eng_crc;
    logic             m_valid, m_ready, m_last, eng_clr, eng_valid, eng_mode, eng_ok;
    logic             busy, done, crc_ok, len_err;
    logic [LEN_W-1:0] frame_len;

    int checks = 0;
    int failures = 0;

    // Stimulus stream and reference expectations
    logic [7:0] fb[$];
    logic [7:0] in_data[$];
    bit         in_last[$], in_mode[$], in_first[$];
    logic [7:0] exp_data[$];
    bit         exp_last[$], exp_ok[$], exp_lerr[$];
    int         exp_len[$];
    int         nframes;

    // Observations
    logic [7:0] out_data[$];
    bit         out_last[$], res_ok[$], res_lerr[$];
    int         res_len[$], out_cyc[$], done_cyc[$], hs_cyc[$], start_cyc[$];
    int         clr_count, mvalid_cycles, stab_err;

    always #5 clk = ~clk;

    crc8_frame_seq #(.MAX_LEN(MAX_LEN)) dut (
        .clk(clk), .rst(rst), .mode(mode),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .eng_clr(eng_clr), .eng_valid(eng_valid), .eng_data(eng_data), .eng_mode(eng_mode),
        .eng_rx_crc(eng_rx_crc), .eng_crc(eng_crc), .eng_ok(eng_ok),
        .busy(busy), .done(done), .crc_ok(crc_ok), .len_err(len_err), .frame_len(frame_len)
    );

    function automatic logic [7:0] crc8_byte(input logic [7:0] c, input logic [7:0] d);
        logic [7:0] r;
        r = c ^ d;
        for (int i = 0; i < 8; i++) r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
        return r;
    endfunction

    // CRC-8 engine: registered, cleared by eng_clr, one byte per eng_valid
    always @(posedge clk) begin
        if (rst || eng_clr) eng_crc <= 8'h00;
        else if (eng_valid) eng_crc <= crc8_byte(eng_crc, eng_data);
    end
    assign eng_ok = (eng_crc == eng_rx_crc);

    function automatic logic [7:0] crc_of(input int n);
        logic [7:0] c;
        c = 8'h00;
        for (int i = 0; i < n; i++) c = crc8_byte(c, fb[i]);
        return c;
    endfunction

    task automatic clear_stream();
        in_data.delete(); in_last.delete(); in_mode.delete(); in_first.delete();
        exp_data.delete(); exp_last.delete(); exp_ok.delete(); exp_lerr.delete(); exp_len.delete();
        nframes = 0;
    endtask

    // Queue the frame in fb and derive what the sequencer should produce for it
    task automatic add_frame(input bit m);
        int n, k;
        n = fb.size();
        for (int i = 0; i < n; i++) begin
            in_data.push_back(fb[i]); in_last.push_back(i == n - 1);
            in_mode.push_back(m);     in_first.push_back(i == 0);
        end
        if (!m) begin
            k = (n > MAX_LEN) ? MAX_LEN : n;
            for (int i = 0; i < k; i++) begin
                exp_data.push_back(fb[i]); exp_last.push_back(1'b0);
            end
            exp_data.push_back((n > MAX_LEN) ? ~crc_of(k) : crc_of(k));
            exp_last.push_back(1'b1);
            exp_ok.push_back(1'b0); exp_lerr.push_back(n > MAX_LEN); exp_len.push_back(k);
        end else begin
            k = n - 1;
            if (k > MAX_LEN) begin
                exp_ok.push_back(1'b0); exp_lerr.push_back(1'b1); exp_len.push_back(MAX_LEN);
            end else begin
                exp_ok.push_back(crc_of(k) == fb[k]); exp_lerr.push_back(1'b0); exp_len.push_back(k);
            end
        end
        nframes++;
    endtask

    // Drives the queued stream; rdy_kind 0=always ready, 1=toggle, 2=random
    task automatic run_stream(input int rdy_kind, output bit tmo);
        int idx, cyc, dones, budget;
        bit stall_prev;
        logic [7:0] d_prev;
        logic l_prev;
        out_data.delete(); out_last.delete(); res_ok.delete(); res_lerr.delete(); res_len.delete();
        out_cyc.delete(); done_cyc.delete(); hs_cyc.delete(); start_cyc.delete();
        clr_count = 0; mvalid_cycles = 0; stab_err = 0;
        idx = 0; cyc = 0; dones = 0; stall_prev = 0; d_prev = 8'h00; l_prev = 1'b0;
        budget = 40 * in_data.size() + 100;
        while (dones < nframes && cyc < budget) begin
            if (idx < in_data.size()) begin
                s_valid = 1'b1; s_data = in_data[idx]; s_last = in_last[idx]; mode = in_mode[idx];
            end else begin
                s_valid = 1'b0; s_last = 1'b0; s_data = 8'($urandom);
            end
            case (rdy_kind)
                0: m_ready = 1'b1;
                1: m_ready = (cyc % 2 == 0);
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
            @(negedge clk);
            if (m_valid) mvalid_cycles++;
            if (stall_prev && (!m_valid || m_data !== d_prev || m_last !== l_prev)) stab_err++;
            stall_prev = m_valid && !m_ready; d_prev = m_data; l_prev = m_last;
            if (m_valid && m_ready) begin
                out_data.push_back(m_data); out_last.push_back(m_last); out_cyc.push_back(cyc);
            end
            if (eng_clr) clr_count++;
            if (done) begin
                res_ok.push_back(crc_ok); res_lerr.push_back(len_err);
                res_len.push_back(int'(frame_len)); done_cyc.push_back(cyc); dones++;
            end
            if (s_valid && s_ready) begin
                hs_cyc.push_back(cyc);
                if (in_first[idx]) start_cyc.push_back(cyc);
                idx++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b1;
        tmo = (dones < nframes);
    endtask

    task automatic test_reset();
        rst = 1'b1; mode = 1'b0; s_valid = 1'b1; s_data = 8'h3C; s_last = 1'b0; m_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({s_ready, m_valid, m_last, eng_clr, eng_valid, done, crc_ok, len_err, busy} !== 9'b0) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=000000000",
                     {s_ready, m_valid, m_last, eng_clr, eng_valid, done, crc_ok, len_err, busy});
        end
        checks++;
        if (frame_len !== '0 || eng_rx_crc !== 8'h00) begin
            failures++; $display("FAIL reset_regs frame_len=%0d rx=%h exp 0/00", frame_len, eng_rx_crc);
        end
        @(posedge clk); #1;
        rst = 1'b0; s_valid = 1'b0;
        $display("reset: flags and registers sampled");
    endtask

    task automatic test_generate();
        bit tmo;
        clear_stream();
        fb = '{8'hA5, 8'h5A}; add_frame(1'b0);
        run_stream(0, tmo);
        checks++;
        if (tmo || out_data.size() != 3 || res_ok.size() != 1) begin
            failures++; $display("FAIL gen_counts beats=%0d dones=%0d exp 3/1", out_data.size(), res_ok.size());
        end else begin
            checks++;
            if ({out_data[0], out_data[1], out_data[2]} !== 24'hA55AD8) begin
                failures++; $display("FAIL gen_data got=%h%h%h exp=a55ad8", out_data[0], out_data[1], out_data[2]);
            end
            checks++;
            if ({out_last[0], out_last[1], out_last[2]} !== 3'b001) begin
                failures++; $display("FAIL gen_last got=%b%b%b exp=001", out_last[0], out_last[1], out_last[2]);
            end
            checks++;
            if (res_len[0] != 2 || res_lerr[0] !== 1'b0 || res_ok[0] !== 1'b0) begin
                failures++; $display("FAIL gen_result len=%0d lerr=%b ok=%b exp 2/0/0", res_len[0], res_lerr[0], res_ok[0]);
            end
            checks++;
            if (done_cyc[0] - out_cyc[2] != 1) begin
                failures++; $display("FAIL gen_latency got=%0d exp=1", done_cyc[0] - out_cyc[2]);
            end
        end
        $display("generate: A5 5A -> beats=%0d", out_data.size());
    endtask

    task automatic test_check();
        bit tmo;
        logic [7:0] rx[4];
        bit ok_exp[4];
        int len_exp[4];
        rx = '{8'hD8, 8'hD9, 8'h00, 8'h5C};
        ok_exp = '{1'b1, 1'b0, 1'b1, 1'b0};
        len_exp = '{2, 2, 0, 0};
        for (int t = 0; t < 4; t++) begin
            clear_stream();
            if (t < 2) fb = '{8'hA5, 8'h5A, rx[t]};
            else fb = '{rx[t]};
            add_frame(1'b1);
            run_stream(0, tmo);
            checks++;
            if (tmo || res_ok.size() != 1) begin
                failures++; $display("FAIL chk%0d_done dones=%0d exp=1", t, res_ok.size());
            end else begin
                checks++;
                if (res_ok[0] !== ok_exp[t] || res_lerr[0] !== 1'b0 || res_len[0] != len_exp[t]) begin
                    failures++;
                    $display("FAIL chk%0d_result ok=%b lerr=%b len=%0d exp %b/0/%0d",
                             t, res_ok[0], res_lerr[0], res_len[0], ok_exp[t], len_exp[t]);
                end
                checks++;
                if (done_cyc[0] - hs_cyc[hs_cyc.size() - 1] != 2) begin
                    failures++; $display("FAIL chk%0d_latency got=%0d exp=2", t, done_cyc[0] - hs_cyc[hs_cyc.size() - 1]);
                end
            end
            checks++;
            if (mvalid_cycles != 0 || clr_count != 1) begin
                failures++; $display("FAIL chk%0d_side mvalid=%0d clr=%0d exp 0/1", t, mvalid_cycles, clr_count);
            end
            $display("check: frame %0d rx=%h ok=%0d", t, rx[t], ok_exp[t]);
        end
    endtask

    task automatic test_len_err();
        bit tmo;
        clear_stream();
        fb = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66}; add_frame(1'b0);
        fb = '{8'h01, 8'h02, 8'h03, 8'h04}; add_frame(1'b0);
        fb = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70}; add_frame(1'b1);
        fb = '{8'h10, 8'h20, 8'h30, 8'h40}; fb.push_back(crc_of(4)); add_frame(1'b1);
        run_stream(0, tmo);
        checks++;
        if (tmo || out_data.size() != exp_data.size() || res_ok.size() != nframes || hs_cyc.size() != in_data.size()) begin
            failures++;
            $display("FAIL len_counts beats=%0d/%0d dones=%0d/%0d taken=%0d/%0d", out_data.size(), exp_data.size(),
                     res_ok.size(), nframes, hs_cyc.size(), in_data.size());
        end else begin
            for (int i = 0; i < out_data.size(); i++) begin
                checks++;
                if (out_data[i] !== exp_data[i] || out_last[i] !== exp_last[i]) begin
                    failures++; $display("FAIL len_beat%0d got=%h/%b exp=%h/%b", i, out_data[i], out_last[i], exp_data[i], exp_last[i]);
                end
            end
            for (int f = 0; f < nframes; f++) begin
                checks++;
                if (res_ok[f] !== exp_ok[f] || res_lerr[f] !== exp_lerr[f] || res_len[f] != exp_len[f]) begin
                    failures++;
                    $display("FAIL len_frame%0d ok=%b lerr=%b len=%0d exp %b/%b/%0d",
                             f, res_ok[f], res_lerr[f], res_len[f], exp_ok[f], exp_lerr[f], exp_len[f]);
                end
                $display("len_err: frame %0d lerr=%b len=%0d", f, res_lerr[f], res_len[f]);
            end
        end
    endtask

    task automatic test_backpressure();
        bit tmo;
        for (int k = 1; k <= 2; k++) begin
            clear_stream();
            fb = '{8'hA5, 8'h5A}; add_frame(1'b0);
            fb = '{8'($urandom), 8'($urandom), 8'($urandom)}; add_frame(1'b0);
            run_stream(k, tmo);
            checks++;
            if (tmo || out_data.size() != exp_data.size() || stab_err != 0) begin
                failures++;
                $display("FAIL bp%0d_stream beats=%0d exp=%0d unstable=%0d", k, out_data.size(), exp_data.size(), stab_err);
            end else begin
                for (int i = 0; i < out_data.size(); i++) begin
                    checks++;
                    if (out_data[i] !== exp_data[i] || out_last[i] !== exp_last[i]) begin
                        failures++; $display("FAIL bp%0d_beat%0d got=%h/%b exp=%h/%b", k, i, out_data[i], out_last[i], exp_data[i], exp_last[i]);
                    end
                end
            end
            $display("backpressure: ready kind %0d beats=%0d", k, out_data.size());
        end
    endtask

    task automatic test_back_to_back();
        bit tmo;
        clear_stream();
        fb = '{8'hA5, 8'h5A}; add_frame(1'b0);
        fb = '{8'hA5, 8'h5A}; add_frame(1'b0);
        fb = '{8'hA5, 8'h5A, 8'hD8}; add_frame(1'b1);
        fb = '{8'h77}; add_frame(1'b0);
        run_stream(0, tmo);
        checks++;
        if (tmo || start_cyc.size() != nframes || done_cyc.size() != nframes || out_data.size() != exp_data.size()) begin
            failures++; $display("FAIL b2b_counts starts=%0d dones=%0d beats=%0d", start_cyc.size(), done_cyc.size(), out_data.size());
        end else begin
            checks++;
            if (out_data[2] !== 8'hD8 || out_data[5] !== 8'hD8 || res_ok[2] !== 1'b1) begin
                failures++; $display("FAIL b2b_crc got=%h,%h ok=%b exp=d8,d8 ok=1", out_data[2], out_data[5], res_ok[2]);
            end
            for (int f = 1; f < nframes; f++) begin
                checks++;
                if (start_cyc[f] - done_cyc[f - 1] != 2) begin
                    failures++; $display("FAIL b2b_gap%0d got=%0d exp=2", f, start_cyc[f] - done_cyc[f - 1]);
                end
            end
            checks++;
            if (clr_count != nframes) begin
                failures++; $display("FAIL b2b_clr got=%0d exp=%0d", clr_count, nframes);
            end
        end
        $display("back_to_back: %0d frames", nframes);
    endtask

    task automatic test_reset_midframe();
        bit tmo;
        int stray;
        stray = 0;
        mode = 1'b0; s_valid = 1'b1; s_last = 1'b0; m_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s_data = 8'($urandom);
            @(negedge clk); if (done) stray++;
            @(posedge clk); #1;
        end
        rst = 1'b1; s_valid = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (m_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || stray != 0) begin
            failures++; $display("FAIL rstmid_state m_valid=%b busy=%b done=%b stray=%0d exp 0/0/0/0", m_valid, busy, done, stray);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        clear_stream();
        fb = '{8'hA5, 8'h5A, 8'hD8}; add_frame(1'b1);
        run_stream(0, tmo);
        checks++;
        if (tmo || res_ok.size() != 1) begin
            failures++; $display("FAIL rstmid_done dones=%0d exp=1", res_ok.size());
        end else if (res_ok[0] !== 1'b1 || res_len[0] != 2) begin
            failures++; $display("FAIL rstmid_result ok=%b len=%0d exp 1/2", res_ok[0], res_len[0]);
        end
        $display("reset_midframe: new frame ok");
    endtask

    task automatic test_random();
        bit tmo;
        int n;
        bit m;
        clear_stream();
        for (int f = 0; f < 30; f++) begin
            m = 1'($urandom_range(0, 1));
            n = m ? $urandom_range(0, 6) : $urandom_range(1, 6);
            fb.delete();
            for (int i = 0; i < n; i++) fb.push_back(8'($urandom));
            if (m) fb.push_back($urandom_range(0, 1) ? crc_of(n) : crc_of(n) ^ 8'(1 << $urandom_range(0, 7)));
            add_frame(m);
        end
        run_stream(2, tmo);
        checks++;
        if (tmo || out_data.size() != exp_data.size() || res_ok.size() != nframes || stab_err != 0 || clr_count != nframes) begin
            failures++;
            $display("FAIL rand_counts beats=%0d/%0d dones=%0d/%0d unstable=%0d clr=%0d", out_data.size(), exp_data.size(),
                     res_ok.size(), nframes, stab_err, clr_count);
        end else begin
            for (int i = 0; i < out_data.size(); i++) begin
                checks++;
                if (out_data[i] !== exp_data[i] || out_last[i] !== exp_last[i]) begin
                    failures++; $display("FAIL rand_beat%0d got=%h/%b exp=%h/%b", i, out_data[i], out_last[i], exp_data[i], exp_last[i]);
                end
            end
            for (int f = 0; f < nframes; f++) begin
                checks++;
                if (res_ok[f] !== exp_ok[f] || res_lerr[f] !== exp_lerr[f] || res_len[f] != exp_len[f]) begin
                    failures++;
                    $display("FAIL rand_frame%0d ok=%b lerr=%b len=%0d exp %b/%b/%0d",
                             f, res_ok[f], res_lerr[f], res_len[f], exp_ok[f], exp_lerr[f], exp_len[f]);
                end
                $display("random: frame %0d ok=%b lerr=%b len=%0d", f, res_ok[f], res_lerr[f], res_len[f]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_generate();
        test_check();
        test_len_err();
        test_backpressure();
        test_back_to_back();
        test_reset_midframe();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
